// File: rtl/snd_pkg.sv
// Shared types and constants for the sound output path.
package snd_pkg;

    localparam int unsigned SND_SAMPLE_W = 8;
    localparam int unsigned SND_OUT_W    = 16;

    localparam logic [SND_SAMPLE_W-1:0] SND_MIDPOINT = 8'h80;

    typedef logic signed [SND_OUT_W-1:0] audio_t;

endpackage

// File: rtl/snd_slew.sv
// Slew / first-order low-pass stage: acc moves toward target by (target-acc)>>>SLEW_SHIFT
// per enable, with a minimum step of one LSB so it always lands exactly on target.
module snd_slew
    import snd_pkg::*;
#(
    parameter int unsigned SLEW_SHIFT = 2
) (
    input  logic   clk,
    input  logic   _reset,
    input  logic   en,
    input  audio_t target,
    output audio_t acc
);

    logic signed [SND_OUT_W:0] diff;
    logic signed [SND_OUT_W:0] step;
    logic signed [SND_OUT_W:0] nextAcc;

    always_comb begin
        diff = {target[SND_OUT_W-1], target} - {acc[SND_OUT_W-1], acc};
        step = diff >>> SLEW_SHIFT;
        // Positive residues below 2^SLEW_SHIFT would otherwise stall short of target.
        if (step == '0 && diff != '0) begin
            step = diff[SND_OUT_W] ? '1 : (SND_OUT_W+1)'(1);
        end
        nextAcc = {acc[SND_OUT_W-1], acc} + step;
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= audio_t'(nextAcc);
        end
    end

endmodule

// File: rtl/mac_sound_out.sv
// Sound-buffer consumer: captures the audio slot word, applies volume/enable, slews the
// result into a signed PCM stream and flags when sample fetches stop arriving.
module mac_sound_out
    import snd_pkg::*;
#(
    parameter int unsigned SLEW_SHIFT  = 2,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk8_en_p,
    input  logic        memoryLatch,
    input  logic        loadSound,
    input  logic [15:0] memoryData,
    input  logic [2:0]  volume,
    input  logic        _sndEnable,
    output audio_t      audio,
    output logic [7:0]  diskSpeed,
    output logic        sampleStrobe,
    output logic        soundStall
);

    localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_LIMIT - 1);

    logic [SND_SAMPLE_W-1:0] sampleQ;
    logic [CNT_W-1:0]        stallCnt;
    logic                    capture;

    logic signed [SND_SAMPLE_W-1:0] s;
    logic signed [11:0]             sExt;
    logic signed [11:0]             gain;
    logic signed [11:0]             p;
    audio_t                         target;

    assign capture = loadSound && memoryLatch;

    always_ff @(posedge clk) begin
        if (!_reset) begin
            sampleQ      <= SND_MIDPOINT;
            diskSpeed    <= '0;
            sampleStrobe <= 1'b0;
            soundStall   <= 1'b0;
            stallCnt     <= '0;
        end else begin
            sampleStrobe <= capture;
            if (capture) begin
                sampleQ    <= memoryData[15:8];
                diskSpeed  <= memoryData[7:0];
                stallCnt   <= '0;
                soundStall <= 1'b0;
            end else if (clk8_en_p && stallCnt != CNT_MAX) begin
                stallCnt <= stallCnt + 1'b1;
                // Fall back to the midpoint so the output slews down to silence.
                if (stallCnt == CNT_LAST) begin
                    soundStall <= 1'b1;
                    sampleQ    <= SND_MIDPOINT;
                end
            end
        end
    end

    always_comb begin
        s      = {~sampleQ[7], sampleQ[6:0]};
        sExt   = {{4{s[7]}}, s};
        gain   = {9'b0, volume} + 12'sd1;
        p      = sExt * gain;
        target = _sndEnable ? '0 : audio_t'({{4{p[11]}}, p} << 4);
    end

    snd_slew #(
        .SLEW_SHIFT (SLEW_SHIFT)
    ) u_slew (
        .clk    (clk),
        ._reset (_reset),
        .en     (clk8_en_p),
        .target (target),
        .acc    (audio)
    );

endmodule

// File: tb/tb_mac_sound_out.sv
// Directed bench: two instances (SLEW_SHIFT 0 and 2) share stimulus; expectations hand-computed.
module tb_mac_sound_out;

    logic        clk = 1'b0;
    logic        _reset;
    logic        clk8_en_p;
    logic        memoryLatch;
    logic        loadSound;
    logic [15:0] memoryData;
    logic [2:0]  volume;
    logic        _sndEnable;

    logic signed [15:0] audio0, audio2;
    logic [7:0]         disk0, disk2;
    logic               strobe0, strobe2;
    logic               stall0, stall2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_sound_out #(.SLEW_SHIFT(0), .STALL_LIMIT(64)) dut0 (
        .clk          (clk),
        ._reset       (_reset),
        .clk8_en_p    (clk8_en_p),
        .memoryLatch  (memoryLatch),
        .loadSound    (loadSound),
        .memoryData   (memoryData),
        .volume       (volume),
        ._sndEnable   (_sndEnable),
        .audio        (audio0),
        .diskSpeed    (disk0),
        .sampleStrobe (strobe0),
        .soundStall   (stall0)
    );

    mac_sound_out #(.SLEW_SHIFT(2), .STALL_LIMIT(64)) dut2 (
        .clk          (clk),
        ._reset       (_reset),
        .clk8_en_p    (clk8_en_p),
        .memoryLatch  (memoryLatch),
        .loadSound    (loadSound),
        .memoryData   (memoryData),
        .volume       (volume),
        ._sndEnable   (_sndEnable),
        .audio        (audio2),
        .diskSpeed    (disk2),
        .sampleStrobe (strobe2),
        .soundStall   (stall2)
    );

    task automatic cyc(input logic en);
        clk8_en_p = en;
        @(posedge clk);
        #1;
        clk8_en_p = 1'b0;
    endtask

    task automatic tick();
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic capture(input logic [15:0] word);
        loadSound = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        memoryData  = word;
        memoryLatch = 1'b1;
        cyc(1'b0);
        memoryLatch = 1'b0;
        cyc(1'b0);
        loadSound = 1'b0;
    endtask

    task automatic test_reset();
        _reset      = 1'b0;
        clk8_en_p   = 1'b0;
        memoryLatch = 1'b0;
        loadSound   = 1'b0;
        memoryData  = 16'h0000;
        volume      = 3'd7;
        _sndEnable  = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        checks++;
        if (audio0 !== 16'sd0 || audio2 !== 16'sd0) begin
            errors++;
            $display("FAIL reset_audio: got %0d/%0d expected 0/0", audio0, audio2);
        end
        checks++;
        if (disk0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_diskSpeed: got %h expected 00", disk0);
        end
        checks++;
        if (strobe0 !== 1'b0 || stall0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got strobe=%b stall=%b expected 0/0", strobe0, stall0);
        end
        _reset = 1'b1;
        cyc(1'b0);
    endtask

    task automatic test_capture();
        volume    = 3'd7;
        loadSound = 1'b1;
        cyc(1'b0);
        checks++;
        if (strobe0 !== 1'b0) begin
            errors++;
            $display("FAIL load_no_latch_strobe: got %b expected 0", strobe0);
        end
        cyc(1'b0);
        memoryData  = 16'hC05A;
        memoryLatch = 1'b1;
        cyc(1'b0);
        memoryLatch = 1'b0;
        checks++;
        if (strobe0 !== 1'b1) begin
            errors++;
            $display("FAIL capture_strobe_high: got %b expected 1", strobe0);
        end
        checks++;
        if (disk0 !== 8'h5A) begin
            errors++;
            $display("FAIL capture_diskSpeed: got %h expected 5a", disk0);
        end
        checks++;
        if (audio0 !== 16'sd0) begin
            errors++;
            $display("FAIL capture_latency: got %0d expected 0", audio0);
        end
        cyc(1'b0);
        loadSound = 1'b0;
        checks++;
        if (strobe0 !== 1'b0) begin
            errors++;
            $display("FAIL capture_strobe_low: got %b expected 0", strobe0);
        end
        tick();
        checks++;
        if (audio0 !== 16'sd8192) begin
            errors++;
            $display("FAIL capture_audio_bypass: got %0d expected 8192", audio0);
        end
        checks++;
        if (audio2 !== 16'sd2048) begin
            errors++;
            $display("FAIL capture_audio_slew: got %0d expected 2048", audio2);
        end
    endtask

    task automatic test_slew();
        int prev;
        prev = 2048;
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 9) capture(16'hC05A);
            tick();
            if (i == 0) begin
                checks++;
                if (audio2 !== 16'sd3584) begin
                    errors++;
                    $display("FAIL slew_step2: got %0d expected 3584", audio2);
                end
            end
            if (i == 1) begin
                checks++;
                if (audio2 !== 16'sd4736) begin
                    errors++;
                    $display("FAIL slew_step3: got %0d expected 4736", audio2);
                end
            end
            checks++;
            if (int'(audio2) < prev || int'(audio2) > 8192) begin
                errors++;
                $display("FAIL slew_monotonic: got %0d expected %0d..8192", audio2, prev);
            end
            prev = int'(audio2);
        end
        checks++;
        if (audio2 !== 16'sd8192) begin
            errors++;
            $display("FAIL slew_converge: got %0d expected 8192", audio2);
        end
    endtask

    task automatic test_mute();
        int prev;
        prev = 8192;
        _sndEnable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 9) capture(16'hC05A);
            tick();
            if (i == 0) begin
                checks++;
                if (audio2 !== 16'sd6144 || audio0 !== 16'sd0) begin
                    errors++;
                    $display("FAIL mute_first_step: got %0d/%0d expected 6144/0", audio2, audio0);
                end
            end
            checks++;
            if (int'(audio2) > prev || int'(audio2) < 0) begin
                errors++;
                $display("FAIL mute_monotonic: got %0d expected 0..%0d", audio2, prev);
            end
            prev = int'(audio2);
        end
        checks++;
        if (audio2 !== 16'sd0) begin
            errors++;
            $display("FAIL mute_final: got %0d expected 0", audio2);
        end
        _sndEnable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 9) capture(16'hC05A);
            tick();
        end
        checks++;
        if (audio2 !== 16'sd8192 || audio0 !== 16'sd8192) begin
            errors++;
            $display("FAIL unmute_final: got %0d/%0d expected 8192/8192", audio2, audio0);
        end
    endtask

    task automatic test_volume();
        volume = 3'd0;
        capture(16'h00FF);
        tick();
        checks++;
        if (audio0 !== -16'sd2048) begin
            errors++;
            $display("FAIL vol0_min: got %0d expected -2048", audio0);
        end
        checks++;
        if (disk0 !== 8'hFF) begin
            errors++;
            $display("FAIL vol0_diskSpeed: got %h expected ff", disk0);
        end
        capture(16'h8000);
        tick();
        checks++;
        if (audio0 !== 16'sd0 || disk0 !== 8'h00) begin
            errors++;
            $display("FAIL midpoint: got audio=%0d disk=%h expected 0/00", audio0, disk0);
        end
    endtask

    task automatic test_stall();
        int prev;
        volume = 3'd7;
        capture(16'hC000);
        tick();
        checks++;
        if (audio0 !== 16'sd8192) begin
            errors++;
            $display("FAIL stall_pre_audio: got %0d expected 8192", audio0);
        end
        for (int i = 0; i < 62; i++) tick();
        checks++;
        if (stall0 !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: got %b after 63 ticks expected 0", stall0);
        end
        tick();
        checks++;
        if (stall0 !== 1'b1 || stall2 !== 1'b1) begin
            errors++;
            $display("FAIL stall_set: got %b/%b after 64 ticks expected 1/1", stall0, stall2);
        end
        checks++;
        if (audio2 !== 16'sd8192) begin
            errors++;
            $display("FAIL stall_pre_slew: got %0d expected 8192", audio2);
        end
        tick();
        checks++;
        if (audio0 !== 16'sd0 || audio2 !== 16'sd6144) begin
            errors++;
            $display("FAIL stall_silence: got %0d/%0d expected 0/6144", audio0, audio2);
        end
        prev = 6144;
        for (int i = 0; i < 45; i++) begin
            tick();
            checks++;
            if (int'(audio2) > prev || int'(audio2) < 0) begin
                errors++;
                $display("FAIL stall_ramp: got %0d expected 0..%0d", audio2, prev);
            end
            prev = int'(audio2);
        end
        checks++;
        if (audio2 !== 16'sd0 || stall0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got audio=%0d stall=%b expected 0/1", audio2, stall0);
        end
        loadSound   = 1'b1;
        memoryData  = 16'hC000;
        memoryLatch = 1'b1;
        cyc(1'b0);
        memoryLatch = 1'b0;
        loadSound   = 1'b0;
        checks++;
        if (stall0 !== 1'b0 || strobe0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_clear: got stall=%b strobe=%b expected 0/1", stall0, strobe0);
        end
    endtask

    task automatic test_reset_midramp();
        tick();
        tick();
        checks++;
        if (audio2 !== 16'sd3584) begin
            errors++;
            $display("FAIL midramp_pre: got %0d expected 3584", audio2);
        end
        _reset = 1'b0;
        cyc(1'b0);
        checks++;
        if (audio2 !== 16'sd0 || audio0 !== 16'sd0) begin
            errors++;
            $display("FAIL midramp_audio: got %0d/%0d expected 0/0", audio2, audio0);
        end
        checks++;
        if (disk2 !== 8'h00 || stall2 !== 1'b0) begin
            errors++;
            $display("FAIL midramp_state: got disk=%h stall=%b expected 00/0", disk2, stall2);
        end
        _reset = 1'b1;
        cyc(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 63; i++) tick();
        checks++;
        if (stall0 !== 1'b0) begin
            errors++;
            $display("FAIL coincide_pre: got %b expected 0", stall0);
        end
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        loadSound   = 1'b1;
        memoryLatch = 1'b1;
        memoryData  = 16'hC000;
        cyc(1'b1);
        loadSound   = 1'b0;
        memoryLatch = 1'b0;
        checks++;
        if (stall0 !== 1'b0) begin
            errors++;
            $display("FAIL coincide_priority: got %b expected 0", stall0);
        end
        checks++;
        if (audio0 !== 16'sd0) begin
            errors++;
            $display("FAIL coincide_latency: got %0d expected 0", audio0);
        end
        tick();
        checks++;
        if (audio0 !== 16'sd8192) begin
            errors++;
            $display("FAIL coincide_audio: got %0d expected 8192", audio0);
        end
        for (int i = 0; i < 62; i++) tick();
        checks++;
        if (stall0 !== 1'b0) begin
            errors++;
            $display("FAIL coincide_cleared: got %b after 63 ticks expected 0", stall0);
        end
        tick();
        checks++;
        if (stall0 !== 1'b1) begin
            errors++;
            $display("FAIL coincide_limit: got %b after 64 ticks expected 1", stall0);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_slew();
        test_mute();
        test_volume();
        test_stall();
        test_reset_midramp();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
